pc_fetch: RTL
=============

# pc_fetch

Program-counter register and instruction-fetch sequencer for the single-cycle MIPS core. It holds the current 30-bit word PC (`pcout`) that feeds the `npc` next-PC unit and instruction memory. It runs a request/acknowledge fetch to instruction memory and presents the fetched word to decode. On each retirement it loads `newpc` produced by `npc`.

## Interface
- `RESET_PC`, 30'h0000_0C00, word address loaded on reset (byte address 0x0000_3000)
- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  reset; one clock, reset is asynchronous and active-low
- `newpc`  input  30  next word PC from `npc`
- `pcout`  output  30  current word PC, to `npc` and imem
- `imem_req`  output  1  fetch request
- `imem_addr`  output  30  fetch word address, always equal to `pcout`
- `imem_ack`  input  1  imem data valid this cycle
- `imem_rdata`  input  32  instruction word
- `stall`  input  1  downstream cannot retire the current instruction
- `instr`  output  32  registered instruction
- `instr_valid`  output  1  `instr` is valid and executing
- `fetch_cnt`  output  32  fetched-instruction counter (see Configuration)

## Operation
- Three-state FSM: IDLE, FETCH, EXEC.
- Reset (async, `rst_n`=0) forces:
  - state IDLE, `pcout`=`RESET_PC`
  - `instr`=0, `instr_valid`=0, `imem_req`=0, `fetch_cnt`=0
- IDLE: `imem_req`=0. Goes to FETCH unconditionally on the next edge.
- FETCH:
  - `imem_req`=1 (decoded from registered state, glitch-free).
  - On an edge with `imem_ack`=1: `instr`<=`imem_rdata`, `instr_valid`<=1, go to EXEC.
  - On an edge with `imem_ack`=0: stay; `imem_req` stays high and address stable.
- EXEC:
  - `imem_req`=0; `instr_valid`=1; `npc` derives `newpc` from `pcout` and `instr`.
  - On an edge with `stall`=0: `pcout`<=`newpc`, `instr_valid`<=0, go to FETCH.
  - On an edge with `stall`=1: hold `pcout`, `instr`, `instr_valid`.
  - `imem_ack` is ignored in EXEC and IDLE.
- `pcout` changes only on the EXEC→FETCH transition or on reset.
- Arithmetic and wrap:
  - No arithmetic in this block; `newpc` is taken verbatim, all 30 bits.
  - 30'h3FFF_FFFF → 30'h0 is legal and is not flagged.
- `stall` and `imem_ack` both high in FETCH: the ack wins and is captured; `stall` is consulted only in EXEC.
- Reset asserted mid-FETCH or mid-EXEC: outputs clear immediately (asynchronously) and any pending ack is dropped. After release, fetch restarts at `RESET_PC`.

## Timing
- After `rst_n` rises:
  - edge 1: IDLE→FETCH.
  - `imem_req` high from edge 1 until the ack edge.
- Minimum instruction period is 2 cycles (zero-wait memory with `imem_ack` in the first FETCH cycle):
  - FETCH cycle, then EXEC cycle.
  - `pcout` updates at the end of EXEC.
- Memory wait of N cycles adds N cycles in FETCH. Stall of M cycles adds M cycles in EXEC.
- Fetch latency: `instr` and `instr_valid` are valid the cycle after the ack cycle.
- All outputs are registered or decoded from registered state; there is no combinational path from input to output.

## Configuration
- Macro `PC_FETCH_CNT_EN`.
- Defined:
  - `fetch_cnt` increments by 1 on every FETCH→EXEC capture edge.
  - Wraps 32'hFFFF_FFFF→0.
  - Cleared only by reset.
- Undefined: `fetch_cnt` is tied to 32'h0 and no counter flops are built. The port list is identical either way.

## Test plan
- Reset and startup:
  - Stimulus: hold `rst_n`=0 for 3 cycles, then release.
  - Required: during reset `pcout`=30'h0C00, `imem_req`=0, `instr_valid`=0. Edge 1 after release gives `imem_req`=1, `imem_addr`=30'h0C00.
- Zero-wait fetch:
  - Stimulus: `imem_ack`=1 in the first FETCH cycle with `imem_rdata`=32'h2408_0005, `newpc`=30'h0C01, `stall`=0.
  - Required: `instr`=32'h2408_0005 with `instr_valid`=1 for one cycle, then `pcout`=30'h0C01 and `imem_req`=1.
- Wait states:
  - Stimulus: `imem_ack` held 0 for 3 FETCH cycles, then 1.
  - Required: `imem_req` stays 1 for 4 cycles with `imem_addr` stable; `instr_valid` rises exactly one cycle after the ack.
- Stall:
  - Stimulus: `stall`=1 for 5 EXEC cycles while `newpc` changes every cycle.
  - Required: `pcout` and `instr` are unchanged for all 5 cycles. On the first cycle with `stall`=0, `pcout` takes the `newpc` value present at that edge.
- Reset mid-FETCH:
  - Stimulus: pull `rst_n` low mid-FETCH with `pcout`=30'h3FFF_FFFF, then release.
  - Required: `pcout` returns to 30'h0C00 immediately, without waiting for a clock. A later ack while in IDLE is ignored.
- Counter (with `PC_FETCH_CNT_EN`):
  - Stimulus: force the counter to 32'hFFFF_FFFE, then run 3 fetches.
  - Required: `fetch_cnt` reads FFFF_FFFF, then 0, then 1. Without the macro it reads 0 throughout.

Source files
------------

// File: rtl/pc_fetch.sv
// pc_fetch: program-counter register and instruction-fetch sequencer for the
// single-cycle MIPS core. Holds the 30-bit word PC, runs a req/ack fetch to
// instruction memory and presents the fetched word to decode. Each retired
// instruction loads the next PC supplied by the npc unit.
//
// Optional feature: define PC_FETCH_CNT_EN to build the fetched-instruction
// counter on fetch_cnt. Without it fetch_cnt reads constant zero and no counter
// flops exist; the port list is the same in both builds.
//
// Every output comes straight from a flop, so there is no combinational path
// from any input to any output.

module pc_fetch #(
  parameter logic [29:0] RESET_PC = 30'h0000_0C00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [29:0] newpc,
  output logic [29:0] pcout,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_e;

  state_e      r_state;
  logic [29:0] r_pc;
  logic [31:0] r_instr;
  logic        r_instr_valid;
  logic        r_imem_req;
  logic        w_capture;

  // A fetch completes on any edge where memory acknowledges while in FETCH;
  // an ack seen in IDLE or EXEC is ignored.
  assign w_capture = (r_state == ST_FETCH) && imem_ack;

  // Sequencer: the state, PC, instruction latch and request/valid flags are all
  // updated together so the outputs always agree with the state they encode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_instr       <= 32'h0000_0000;
      r_instr_valid <= 1'b0;
      r_imem_req    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // First edge after reset release always starts a fetch.
          r_state    <= ST_FETCH;
          r_imem_req <= 1'b1;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            // Ack wins over stall here: stall only matters while executing.
            r_instr       <= imem_rdata;
            r_instr_valid <= 1'b1;
            r_imem_req    <= 1'b0;
            r_state       <= ST_EXEC;
          end else begin
            // Wait state: request held high, address (r_pc) untouched.
            r_imem_req <= 1'b1;
            r_state    <= ST_FETCH;
          end
        end
        ST_EXEC: begin
          if (!stall) begin
            // Retire: take the next PC verbatim (no arithmetic, wraps freely).
            r_pc          <= newpc;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b1;
            r_state       <= ST_FETCH;
          end else begin
            // Stalled: PC, instruction and valid all hold.
            r_state <= ST_EXEC;
          end
        end
        default: begin
          // Unreachable encoding: fall back to a clean idle.
          r_state       <= ST_IDLE;
          r_instr_valid <= 1'b0;
          r_imem_req    <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_FETCH_CNT_EN
  logic [31:0] r_fetch_cnt;

  // Counts completed fetches; wraps naturally at 32 bits, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt <= 32'h0000_0000;
    end else if (w_capture) begin
      r_fetch_cnt <= r_fetch_cnt + 32'h0000_0001;
    end else begin
      r_fetch_cnt <= r_fetch_cnt;
    end
  end

  assign fetch_cnt = r_fetch_cnt;
`else
  // Counter not built: the capture strobe has no other consumer.
  logic w_capture_unused;
  assign w_capture_unused = w_capture;
  assign fetch_cnt        = 32'h0000_0000;
`endif

  assign pcout       = r_pc;
  assign imem_addr   = r_pc;
  assign imem_req    = r_imem_req;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;

endmodule
